int_mul_tiled: RTL and testbench

//  Pipelined unsigned LOGQ x LOGQ integer multiplier producing the full 2*LOGQ-bit

---
 rtl/int_mul_tiled.sv | 164 ++++++++++++++++
 tb/tb_int_mul_tiled.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/int_mul_tiled.sv
// Pipelined unsigned LOGQ x LOGQ multiplier built from DSP-sized tile products
// and a balanced adder tree; qH and the valid flag are delayed to match C.
module int_mul_tiled #(
  parameter int unsigned LOGQ   = 60,
  parameter int unsigned LOGQH  = 17,
  parameter int unsigned TILE_A = 26,
  parameter int unsigned TILE_B = 17,
  parameter int unsigned FF_IN  = 1,
  parameter int unsigned FF_MUL = 1,
  parameter int unsigned FF_SUM = 1,
  parameter int unsigned FF_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [LOGQ-1:0]    A,
  input  logic [LOGQ-1:0]    B,
  input  logic [LOGQH-1:0]   qH,
  output logic               out_valid,
  output logic [2*LOGQ-1:0]  C,
  output logic [LOGQH-1:0]   qH_out
);

  localparam int unsigned K        = 2 * LOGQ;
  localparam int unsigned NA       = (LOGQ + TILE_A - 1) / TILE_A;
  localparam int unsigned NB       = (LOGQ + TILE_B - 1) / TILE_B;
  localparam int unsigned NT       = NA * NB;
  localparam int unsigned PA       = NA * TILE_A;
  localparam int unsigned PB       = NB * TILE_B;
  localparam int unsigned PW       = TILE_A + TILE_B;
  localparam int unsigned WS       = PA + PB;
  localparam int unsigned ADD_LVLS = (NT > 1) ? $clog2(NT) : 0;
  localparam int unsigned LAT      = FF_IN + FF_MUL + FF_SUM * ADD_LVLS + FF_OUT;

  // Number of live terms entering tree level l.
  function automatic int nodes_at(input int l);
    return (int'(NT) + (1 << l) - 1) >> l;
  endfunction

  generate
    if (TILE_A > 26 || TILE_B > 17 || LOGQ < 2) begin : g_bad_param
      $fatal(1, "int_mul_tiled: illegal parameters (TILE_A<=26, TILE_B<=17, LOGQ>=2)");
    end
  endgenerate

  logic [LOGQ-1:0] w_a;
  logic [LOGQ-1:0] w_b;

  generate
    if (FF_IN != 0) begin : g_in_ff
      logic [LOGQ-1:0] r_a;
      logic [LOGQ-1:0] r_b;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else begin
          r_a <= A;
          r_b <= B;
        end
      end
      assign w_a = r_a;
      assign w_b = r_b;
    end else begin : g_in_comb
      assign w_a = A;
      assign w_b = B;
    end
  endgenerate

  logic [PA-1:0] w_a_pad;
  logic [PB-1:0] w_b_pad;
  assign w_a_pad = PA'(w_a);
  assign w_b_pad = PB'(w_b);

  // Level 0 holds the shifted tile products; level ADD_LVLS element 0 is the product.
  logic [K-1:0] w_lvl [ADD_LVLS+1][NT];

  generate
    for (genvar i = 0; i < int'(NA); i++) begin : g_ta
      for (genvar j = 0; j < int'(NB); j++) begin : g_tb
        localparam int unsigned SH = i * TILE_A + j * TILE_B;
        logic [PW-1:0] w_prod;
        logic [K-1:0]  w_sh;
        assign w_prod = PW'(w_a_pad[i*TILE_A +: TILE_A]) * PW'(w_b_pad[j*TILE_B +: TILE_B]);
        assign w_sh   = K'(WS'(w_prod) << SH);
        if (FF_MUL != 0) begin : g_mul_ff
          logic [K-1:0] r_p;
          always_ff @(posedge clk or posedge rst) begin
            if (rst) r_p <= '0;
            else     r_p <= w_sh;
          end
          assign w_lvl[0][i*NB+j] = r_p;
        end else begin : g_mul_comb
          assign w_lvl[0][i*NB+j] = w_sh;
        end
      end
    end
  endgenerate

  // Pairwise reduction; an odd leftover term passes through its level.
  generate
    for (genvar l = 0; l < int'(ADD_LVLS); l++) begin : g_lvl
      for (genvar k = 0; k < int'(NT); k++) begin : g_node
        if (k < nodes_at(l + 1)) begin : g_used
          logic [K-1:0] w_s;
          if (2 * k + 1 < nodes_at(l)) begin : g_add
            assign w_s = w_lvl[l][2*k] + w_lvl[l][2*k+1];
          end else begin : g_pass
            assign w_s = w_lvl[l][2*k];
          end
          if (FF_SUM != 0) begin : g_sum_ff
            logic [K-1:0] r_s;
            always_ff @(posedge clk or posedge rst) begin
              if (rst) r_s <= '0;
              else     r_s <= w_s;
            end
            assign w_lvl[l+1][k] = r_s;
          end else begin : g_sum_comb
            assign w_lvl[l+1][k] = w_s;
          end
        end else begin : g_idle
          assign w_lvl[l+1][k] = '0;
        end
      end
    end
  endgenerate

  logic [K-1:0] w_root;
  assign w_root = w_lvl[ADD_LVLS][0];

  generate
    if (FF_OUT != 0) begin : g_out_ff
      logic [K-1:0] r_c;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_c <= '0;
        else     r_c <= w_root;
      end
      assign C = r_c;
    end else begin : g_out_comb
      // Force zero during reset even when the data path has no registers.
      assign C = rst ? '0 : w_root;
    end
  endgenerate

  generate
    if (LAT > 0) begin : g_sb_ff
      logic [LOGQH:0] r_sb [LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(LAT); i++) r_sb[i] <= '0;
        end else begin
          r_sb[0] <= {in_valid, qH};
          for (int i = 1; i < int'(LAT); i++) r_sb[i] <= r_sb[i-1];
        end
      end
      assign out_valid = r_sb[LAT-1][LOGQH];
      assign qH_out    = r_sb[LAT-1][LOGQH-1:0];
    end else begin : g_sb_comb
      assign out_valid = ~rst & in_valid;
      assign qH_out    = rst ? '0 : qH;
    end
  endgenerate

endmodule

// File: tb/tb_int_mul_tiled.sv
// Directed and random checks of int_mul_tiled in three configurations sharing one stimulus:
// defaults (LAT 7), fully combinational (LAT 0) and LOGQ=32 without tree registers (LAT 3).
module tb_int_mul_tiled;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [59:0]  a;
  logic [59:0]  b;
  logic [16:0]  qh;

  logic         v0, v1, v2;
  logic [119:0] c0, c1;
  logic [63:0]  c2;
  logic [16:0]  q0, q1, q2;

  int unsigned  n_chk  = 0;
  int unsigned  n_pass = 0;
  int unsigned  n_fail = 0;

  // Stimulus history: index d is the step driven d steps ago.
  logic         hv [0:7];
  logic [59:0]  ha [0:7];
  logic [59:0]  hb [0:7];
  logic [16:0]  hq [0:7];

  localparam logic [59:0]  ONES   = 60'hFFF_FFFF_FFFF_FFFF;
  localparam logic [119:0] SQ_MAX = 120'hFFFFFFFFFFFFFFE000000000000001;

  always #5 clk = ~clk;

  int_mul_tiled u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .qH(qh),
    .out_valid(v0), .C(c0), .qH_out(q0)
  );

  int_mul_tiled #(.FF_IN(0), .FF_MUL(0), .FF_SUM(0), .FF_OUT(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .qH(qh),
    .out_valid(v1), .C(c1), .qH_out(q1)
  );

  int_mul_tiled #(.LOGQ(32), .FF_SUM(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a[31:0]), .B(b[31:0]), .qH(qh),
    .out_valid(v2), .C(c2), .qH_out(q2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [59:0] r60();
    return 60'({$urandom(), $urandom()});
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 8; i++) begin
      hv[i] = 1'b0; ha[i] = '0; hb[i] = '0; hq[i] = '0;
    end
  endtask

  task automatic chk_all();
    chk("d0_valid", 128'(v0), 128'(hv[7]));
    if (hv[7]) begin
      chk("d0_c",  128'(c0), 128'(ha[7]) * 128'(hb[7]));
      chk("d0_qh", 128'(q0), 128'(hq[7]));
    end
    chk("d1_valid", 128'(v1), 128'(hv[0]));
    if (hv[0]) begin
      chk("d1_c",  128'(c1), 128'(ha[0]) * 128'(hb[0]));
      chk("d1_qh", 128'(q1), 128'(hq[0]));
    end
    chk("d2_valid", 128'(v2), 128'(hv[3]));
    if (hv[3]) begin
      chk("d2_c",  128'(c2), 128'(ha[3][31:0]) * 128'(hb[3][31:0]));
      chk("d2_qh", 128'(q2), 128'(hq[3]));
    end
  endtask

  // One cycle: drive at the falling edge, record, then check all three DUTs.
  task automatic step(input logic v, input logic [59:0] x, input logic [59:0] y,
                      input logic [16:0] q);
    @(negedge clk);
    rst = 1'b0; in_valid = v; a = x; b = y; qh = q;
    for (int i = 7; i > 0; i--) begin
      hv[i] = hv[i-1]; ha[i] = ha[i-1]; hb[i] = hb[i-1]; hq[i] = hq[i-1];
    end
    hv[0] = v; ha[0] = x; hb[0] = y; hq[0] = q;
    #1;
    chk_all();
  endtask

  task automatic directed(input string tag, input logic [59:0] x, input logic [59:0] y,
                          input logic [16:0] q, input logic [119:0] exp);
    step(1'b1, x, y, q);
    chk({tag, "_lat0"}, 128'(c1), 128'(exp));
    repeat (7) step(1'b0, '0, '0, '0);
    chk({tag, "_valid"}, 128'(v0), 128'(1'b1));
    chk({tag, "_c"},     128'(c0), 128'(exp));
    chk({tag, "_qh"},    128'(q0), 128'(q));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; qh = '0;
    clear_hist();

    // Reset held with live inputs: every output stays zero.
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1; a = r60(); b = r60(); qh = 17'($urandom());
      #1;
      chk("rst_v0", 128'(v0), 128'(0));
      chk("rst_c0", 128'(c0), 128'(0));
      chk("rst_q0", 128'(q0), 128'(0));
      chk("rst_v1", 128'(v1), 128'(0));
      chk("rst_c1", 128'(c1), 128'(0));
      chk("rst_q1", 128'(q1), 128'(0));
      chk("rst_v2", 128'(v2), 128'(0));
      chk("rst_c2", 128'(c2), 128'(0));
      chk("rst_q2", 128'(q2), 128'(0));
    end
    repeat (8) step(1'b0, '0, '0, '0);

    // Extremes and tile boundaries.
    directed("max",   ONES, ONES, 17'h1ABCD, SQ_MAX);
    directed("zero",  60'd0, ONES, 17'h00001, 120'd0);
    directed("edge",  60'h400_0000, 60'h2_0000, 17'h15555, 120'h800_0000_0000);
    directed("tmax",  60'h3FF_FFFF, 60'h1_FFFF, 17'h0AAAA, 120'h7FF_FBFE_0001);

    // Random stream with about 30% gaps.
    for (int n = 0; n < 2000; n++)
      step(($urandom_range(0, 99) >= 30), r60(), r60(), 17'($urandom()));

    // Mid-stream reset between edges while operations are in flight.
    repeat (12) step(1'b1, r60(), r60(), 17'($urandom()));
    @(posedge clk);
    #2;
    chk("pre_rst_v0", 128'(v0), 128'(1'b1));
    rst = 1'b1;
    #1;
    chk("async_v0", 128'(v0), 128'(0));
    chk("async_c0", 128'(c0), 128'(0));
    chk("async_q0", 128'(q0), 128'(0));
    chk("async_v2", 128'(v2), 128'(0));
    chk("async_c2", 128'(c2), 128'(0));
    clear_hist();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) step(1'b0, r60(), r60(), 17'($urandom()));
    step(1'b1, 60'h123_4567_89AB_CDEF, 60'hFED_CBA9_8765_4321, 17'h0F0F0);
    repeat (7) step(1'b0, '0, '0, '0);
    for (int n = 0; n < 200; n++)
      step(($urandom_range(0, 99) >= 30), r60(), r60(), 17'($urandom()));
    repeat (8) step(1'b0, '0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
